// File: rtl/alu_decode_stage_pkg.sv
// Shared constants for the ALU decode stage: op bit indices, MIPS opcode/funct
// encodings and the decoder result bundle.
package alu_decode_stage_pkg;

  localparam int unsigned AluOpW = 15;

  localparam int unsigned AluAnd  = 0;
  localparam int unsigned AluOr   = 1;
  localparam int unsigned AluXor  = 2;
  localparam int unsigned AluNor  = 3;
  localparam int unsigned AluAdd  = 4;
  localparam int unsigned AluSub  = 5;
  localparam int unsigned AluSlt  = 6;
  localparam int unsigned AluSll  = 7;
  localparam int unsigned AluSrl  = 8;
  localparam int unsigned AluSllv = 9;
  localparam int unsigned AluSrlv = 10;
  localparam int unsigned AluSltu = 11;
  localparam int unsigned AluLui  = 12;
  localparam int unsigned AluSra  = 13;
  localparam int unsigned AluSrav = 14;

  localparam logic [5:0] OpSpecial = 6'h00;
  localparam logic [5:0] OpAddi    = 6'h08;
  localparam logic [5:0] OpAddiu   = 6'h09;
  localparam logic [5:0] OpSlti    = 6'h0A;
  localparam logic [5:0] OpSltiu   = 6'h0B;
  localparam logic [5:0] OpAndi    = 6'h0C;
  localparam logic [5:0] OpOri     = 6'h0D;
  localparam logic [5:0] OpXori    = 6'h0E;
  localparam logic [5:0] OpLui     = 6'h0F;

  localparam logic [5:0] FnSll  = 6'h00;
  localparam logic [5:0] FnSrl  = 6'h02;
  localparam logic [5:0] FnSra  = 6'h03;
  localparam logic [5:0] FnSllv = 6'h04;
  localparam logic [5:0] FnSrlv = 6'h06;
  localparam logic [5:0] FnSrav = 6'h07;
  localparam logic [5:0] FnAdd  = 6'h20;
  localparam logic [5:0] FnAddu = 6'h21;
  localparam logic [5:0] FnSub  = 6'h22;
  localparam logic [5:0] FnSubu = 6'h23;
  localparam logic [5:0] FnAnd  = 6'h24;
  localparam logic [5:0] FnOr   = 6'h25;
  localparam logic [5:0] FnXor  = 6'h26;
  localparam logic [5:0] FnNor  = 6'h27;
  localparam logic [5:0] FnSlt  = 6'h2A;
  localparam logic [5:0] FnSltu = 6'h2B;

  typedef struct packed {
    logic [AluOpW-1:0] alu_op;
    logic              use_imm;   // B from immediate instead of rt_value
    logic              imm_zext;  // zero- rather than sign-extend immediate
    logic              dest_rt;   // dest from inst[20:16] instead of inst[15:11]
    logic              ovf_trap;
    logic              illegal;
  } dec_t;

endpackage

// File: rtl/alu_op_decoder.sv
// Combinational opcode/funct decoder producing the one-hot ALU op and operand
// routing controls.
module alu_op_decoder
  import alu_decode_stage_pkg::*;
(
  input  logic [5:0] i_opcode,
  input  logic [5:0] i_funct,
  output dec_t       o_dec
);

  always_comb begin
    o_dec = '0;
    if (i_opcode == OpSpecial) begin
      case (i_funct)
        FnSll:          o_dec.alu_op[AluSll]  = 1'b1;
        FnSrl:          o_dec.alu_op[AluSrl]  = 1'b1;
        FnSra:          o_dec.alu_op[AluSra]  = 1'b1;
        FnSllv:         o_dec.alu_op[AluSllv] = 1'b1;
        FnSrlv:         o_dec.alu_op[AluSrlv] = 1'b1;
        FnSrav:         o_dec.alu_op[AluSrav] = 1'b1;
        FnAdd: begin
          o_dec.alu_op[AluAdd] = 1'b1;
          o_dec.ovf_trap       = 1'b1;
        end
        FnAddu:         o_dec.alu_op[AluAdd]  = 1'b1;
        FnSub: begin
          o_dec.alu_op[AluSub] = 1'b1;
          o_dec.ovf_trap       = 1'b1;
        end
        FnSubu:         o_dec.alu_op[AluSub]  = 1'b1;
        FnAnd:          o_dec.alu_op[AluAnd]  = 1'b1;
        FnOr:           o_dec.alu_op[AluOr]   = 1'b1;
        FnXor:          o_dec.alu_op[AluXor]  = 1'b1;
        FnNor:          o_dec.alu_op[AluNor]  = 1'b1;
        FnSlt:          o_dec.alu_op[AluSlt]  = 1'b1;
        FnSltu:         o_dec.alu_op[AluSltu] = 1'b1;
        default:        o_dec.illegal         = 1'b1;
      endcase
    end else begin
      o_dec.use_imm  = 1'b1;
      o_dec.dest_rt  = 1'b1;
      o_dec.imm_zext = i_opcode[2];  // 0C-0F zero-extend, 08-0B sign-extend
      case (i_opcode)
        OpAddi: begin
          o_dec.alu_op[AluAdd] = 1'b1;
          o_dec.ovf_trap       = 1'b1;
        end
        OpAddiu:        o_dec.alu_op[AluAdd]  = 1'b1;
        OpSlti:         o_dec.alu_op[AluSlt]  = 1'b1;
        OpSltiu:        o_dec.alu_op[AluSltu] = 1'b1;
        OpAndi:         o_dec.alu_op[AluAnd]  = 1'b1;
        OpOri:          o_dec.alu_op[AluOr]   = 1'b1;
        OpXori:         o_dec.alu_op[AluXor]  = 1'b1;
        OpLui:          o_dec.alu_op[AluLui]  = 1'b1;
        default: begin
          o_dec          = '0;
          o_dec.illegal  = 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/alu_decode_stage.sv
// Decode pipeline stage: decodes a MIPS ALU instruction, selects operands and
// holds the result in a valid/allowin handshaked register for execute.
module alu_decode_stage
  import alu_decode_stage_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_allowin,
  input  logic [31:0]       in_inst,
  input  logic [31:0]       in_pc,
  input  logic [31:0]       rs_value,
  input  logic [31:0]       rt_value,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_allowin,
  output logic [AluOpW-1:0] out_alu_op,
  output logic [31:0]       out_alu_a,
  output logic [31:0]       out_alu_b,
  output logic [4:0]        out_shamt,
  output logic [4:0]        out_dest,
  output logic [31:0]       out_pc,
  output logic              out_ovf_trap,
  output logic              out_illegal
);

  dec_t              w_dec;
  logic              w_transfer;
  logic [31:0]       w_imm_ext;
  logic [31:0]       w_alu_b;
  logic [4:0]        w_dest;
  logic              w_unused_rs_field;

  logic              r_valid;
  logic [AluOpW-1:0] r_alu_op;
  logic [31:0]       r_alu_a;
  logic [31:0]       r_alu_b;
  logic [4:0]        r_shamt;
  logic [4:0]        r_dest;
  logic [31:0]       r_pc;
  logic              r_ovf_trap;
  logic              r_illegal;

  alu_op_decoder u_alu_op_decoder (
    .i_opcode (in_inst[31:26]),
    .i_funct  (in_inst[5:0]),
    .o_dec    (w_dec)
  );

  // The rs index is consumed by the register file; only its read data is used here.
  assign w_unused_rs_field = ^in_inst[25:21];

  assign in_allowin = !r_valid || out_allowin;
  assign w_transfer = in_valid && in_allowin && !flush;

  assign w_imm_ext = w_dec.imm_zext ? {16'h0000, in_inst[15:0]}
                                    : {{16{in_inst[15]}}, in_inst[15:0]};
  assign w_alu_b   = w_dec.use_imm ? w_imm_ext : rt_value;
  assign w_dest    = w_dec.illegal ? 5'd0 :
                     (w_dec.dest_rt ? in_inst[20:16] : in_inst[15:11]);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid    <= 1'b0;
      r_alu_op   <= '0;
      r_alu_a    <= '0;
      r_alu_b    <= '0;
      r_shamt    <= '0;
      r_dest     <= '0;
      r_pc       <= '0;
      r_ovf_trap <= 1'b0;
      r_illegal  <= 1'b0;
    end else begin
      if (flush) begin
        r_valid <= 1'b0;
      end else if (in_allowin) begin
        r_valid <= in_valid;
      end
      if (w_transfer) begin
        r_alu_op   <= w_dec.alu_op;
        r_alu_a    <= rs_value;
        r_alu_b    <= w_alu_b;
        r_shamt    <= in_inst[10:6];
        r_dest     <= w_dest;
        r_pc       <= in_pc;
        r_ovf_trap <= w_dec.ovf_trap;
        r_illegal  <= w_dec.illegal;
      end
    end
  end

  assign out_valid    = r_valid;
  assign out_alu_op   = r_alu_op;
  assign out_alu_a    = r_alu_a;
  assign out_alu_b    = r_alu_b;
  assign out_shamt    = r_shamt;
  assign out_dest     = r_dest;
  assign out_pc       = r_pc;
  assign out_ovf_trap = r_ovf_trap;
  assign out_illegal  = r_illegal;

endmodule

// File: tb/tb_alu_decode_stage.sv
// Self-checking bench for alu_decode_stage: mnemonic-level reference model with
// a per-cycle compare process, plus directed literal checks.
module tb_alu_decode_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_allowin;
  logic [31:0] in_inst;
  logic [31:0] in_pc;
  logic [31:0] rs_value;
  logic [31:0] rt_value;
  logic        flush;
  logic        out_valid;
  logic        out_allowin;
  logic [14:0] out_alu_op;
  logic [31:0] out_alu_a;
  logic [31:0] out_alu_b;
  logic [4:0]  out_shamt;
  logic [4:0]  out_dest;
  logic [31:0] out_pc;
  logic        out_ovf_trap;
  logic        out_illegal;

  int checks = 0;
  int errors = 0;

  alu_decode_stage dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_allowin   (in_allowin),
    .in_inst      (in_inst),
    .in_pc        (in_pc),
    .rs_value     (rs_value),
    .rt_value     (rt_value),
    .flush        (flush),
    .out_valid    (out_valid),
    .out_allowin  (out_allowin),
    .out_alu_op   (out_alu_op),
    .out_alu_a    (out_alu_a),
    .out_alu_b    (out_alu_b),
    .out_shamt    (out_shamt),
    .out_dest     (out_dest),
    .out_pc       (out_pc),
    .out_ovf_trap (out_ovf_trap),
    .out_illegal  (out_illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference decode in terms of mnemonics: op index per the ALU op table, -1 = illegal.
  function automatic void model_dec(input logic [31:0] inst, input logic [31:0] rt,
                                    output logic [14:0] op, output logic [31:0] b,
                                    output logic [4:0] dest, output logic trap,
                                    output logic ill);
    int unsigned opc;
    int unsigned fn;
    int idx;
    opc  = inst[31:26];
    fn   = inst[5:0];
    idx  = -1;
    trap = 1'b0;
    b    = rt;
    dest = inst[15:11];
    if (opc == 0) begin
      case (fn)
        'h00: idx = 7;   'h02: idx = 8;   'h03: idx = 13;
        'h04: idx = 9;   'h06: idx = 10;  'h07: idx = 14;
        'h20: begin idx = 4; trap = 1'b1; end
        'h21: idx = 4;
        'h22: begin idx = 5; trap = 1'b1; end
        'h23: idx = 5;
        'h24: idx = 0;   'h25: idx = 1;   'h26: idx = 2;  'h27: idx = 3;
        'h2A: idx = 6;   'h2B: idx = 11;
        default: idx = -1;
      endcase
    end else begin
      dest = inst[20:16];
      if (opc >= 8 && opc <= 11) b = 32'($signed(inst[15:0]));
      else                       b = {16'h0, inst[15:0]};
      case (opc)
        8:  begin idx = 4; trap = 1'b1; end
        9:  idx = 4;   10: idx = 6;   11: idx = 11;
        12: idx = 0;   13: idx = 1;   14: idx = 2;  15: idx = 12;
        default: idx = -1;
      endcase
    end
    if (idx < 0) begin
      op = '0; dest = '0; trap = 1'b0; ill = 1'b1;
    end else begin
      op = 15'(1) << idx; ill = 1'b0;
    end
  endfunction

  // Model state: what the execute-facing register must hold.
  logic        m_init = 1'b0;
  logic        m_valid;
  logic        m_ab_known;
  logic [14:0] m_op;
  logic [31:0] m_a, m_b, m_pc;
  logic [4:0]  m_shamt, m_dest;
  logic        m_trap, m_ill;
  logic [14:0] t_op;
  logic [31:0] t_b;
  logic [4:0]  t_dest;
  logic        t_trap, t_ill, t_allow;

  always @(posedge clk) begin
    if (reset) begin
      m_init <= 1'b1; m_valid <= 1'b0; m_ab_known <= 1'b1;
      m_op <= '0; m_a <= '0; m_b <= '0; m_pc <= '0;
      m_shamt <= '0; m_dest <= '0; m_trap <= 1'b0; m_ill <= 1'b0;
    end else if (m_init) begin
      t_allow = !m_valid || out_allowin;
      if (in_valid && t_allow && !flush) begin
        model_dec(in_inst, rt_value, t_op, t_b, t_dest, t_trap, t_ill);
        m_op <= t_op; m_a <= rs_value; m_b <= t_b; m_pc <= in_pc;
        m_shamt <= in_inst[10:6]; m_dest <= t_dest; m_trap <= t_trap; m_ill <= t_ill;
        m_ab_known <= !t_ill;  // operands of an illegal encoding are don't-care
      end
      m_valid <= flush ? 1'b0 : (t_allow ? in_valid : m_valid);
    end
  end

  always @(negedge clk) begin
    if (m_init) begin
      chk("out_valid", 32'(out_valid), 32'(m_valid));
      chk("in_allowin", 32'(in_allowin), 32'(!m_valid || out_allowin));
      chk("alu_op", 32'(out_alu_op), 32'(m_op));
      chk("shamt", 32'(out_shamt), 32'(m_shamt));
      chk("dest", 32'(out_dest), 32'(m_dest));
      chk("pc", out_pc, m_pc);
      chk("ovf_trap", 32'(out_ovf_trap), 32'(m_trap));
      chk("illegal", 32'(out_illegal), 32'(m_ill));
      if (m_ab_known) begin
        chk("alu_a", out_alu_a, m_a);
        chk("alu_b", out_alu_b, m_b);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rtype(input int rs, input int rt, input int rd,
                                        input int sh, input int fn);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'(sh), 6'(fn)};
  endfunction

  function automatic logic [31:0] itype(input int op, input int rs, input int rt,
                                        input int imm);
    return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
  endfunction

  logic [31:0] tbl[24];

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_inst = '0; in_pc = '0; rs_value = '0;
    rt_value = '0; flush = 1'b0; out_allowin = 1'b1;
    step(); step();
    chk("rst valid", 32'(out_valid), 32'd0);
    chk("rst allowin", 32'(in_allowin), 32'd1);
    chk("rst op", 32'(out_alu_op), 32'd0);
    reset = 1'b0;

    // addiu $2,$1,-1
    in_valid = 1'b1; in_inst = 32'h2422FFFF; rs_value = 32'd5; in_pc = 32'h0000_1000;
    step();
    chk("addiu valid", 32'(out_valid), 32'd1);
    chk("addiu op", 32'(out_alu_op), 32'h0010);
    chk("addiu b", out_alu_b, 32'hFFFFFFFF);
    chk("addiu dest", 32'(out_dest), 32'd2);
    chk("addiu trap", 32'(out_ovf_trap), 32'd0);

    // ori then lui back to back
    in_inst = 32'h3422FFFF; in_pc = 32'h0000_1004;
    step();
    chk("ori op", 32'(out_alu_op), 32'h0002);
    chk("ori b", out_alu_b, 32'h0000FFFF);
    in_inst = 32'h3C031234; in_pc = 32'h0000_1008;
    step();
    chk("lui op", 32'(out_alu_op), 32'h1000);
    chk("lui b", out_alu_b, 32'h00001234);
    chk("lui dest", 32'(out_dest), 32'd3);

    // sra $4,$5,3
    in_inst = 32'h000520C3; rt_value = 32'h80000000; in_pc = 32'h0000_100C;
    step();
    chk("sra op", 32'(out_alu_op), 32'h2000);
    chk("sra shamt", 32'(out_shamt), 32'd3);
    chk("sra dest", 32'(out_dest), 32'd4);
    chk("sra b", out_alu_b, 32'h80000000);

    // add $2,$4,$5 then stall three cycles with sub presented
    in_inst = 32'h00851020; rs_value = 32'h7FFF_FFFF; rt_value = 32'd1;
    step();
    out_allowin = 1'b0; in_inst = 32'h00A41822; rs_value = 32'd9; rt_value = 32'd4;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall allowin", 32'(in_allowin), 32'd0);
      chk("stall op", 32'(out_alu_op), 32'h0010);
      chk("stall a", out_alu_a, 32'h7FFF_FFFF);
      chk("stall trap", 32'(out_ovf_trap), 32'd1);
    end
    out_allowin = 1'b1;
    step();
    chk("sub op", 32'(out_alu_op), 32'h0020);
    chk("sub dest", 32'(out_dest), 32'd3);
    chk("sub a", out_alu_a, 32'd9);

    // illegal opcode 3F, then flush with a valid incoming instruction
    in_inst = 32'hFC000000;
    step();
    chk("ill flag", 32'(out_illegal), 32'd1);
    chk("ill op", 32'(out_alu_op), 32'd0);
    chk("ill dest", 32'(out_dest), 32'd0);
    flush = 1'b1; in_inst = 32'h3422FFFF;
    step();
    chk("flush valid", 32'(out_valid), 32'd0);
    flush = 1'b0; in_valid = 1'b0;
    step();
    chk("post-flush valid", 32'(out_valid), 32'd0);

    // reset during a stall
    in_valid = 1'b1; in_inst = 32'h3C03ABCD; in_pc = 32'h0000_2000;
    step();
    out_allowin = 1'b0; in_inst = 32'h00851020;
    step();
    reset = 1'b1;
    step();
    reset = 1'b0; in_valid = 1'b0;
    chk("rst2 valid", 32'(out_valid), 32'd0);
    chk("rst2 op", 32'(out_alu_op), 32'd0);
    chk("rst2 b", out_alu_b, 32'd0);
    chk("rst2 pc", out_pc, 32'd0);
    chk("rst2 allowin", 32'(in_allowin), 32'd1);

    // Mixed traffic, checked by the model each cycle
    tbl[0]  = rtype(1, 2, 3, 4, 'h00);  tbl[1]  = rtype(1, 2, 3, 5, 'h02);
    tbl[2]  = rtype(6, 7, 8, 0, 'h04);  tbl[3]  = rtype(6, 7, 8, 0, 'h06);
    tbl[4]  = rtype(6, 7, 9, 0, 'h07);  tbl[5]  = rtype(1, 2, 10, 0, 'h21);
    tbl[6]  = rtype(1, 2, 11, 0, 'h23); tbl[7]  = rtype(1, 2, 12, 0, 'h24);
    tbl[8]  = rtype(1, 2, 13, 0, 'h25); tbl[9]  = rtype(1, 2, 14, 0, 'h26);
    tbl[10] = rtype(1, 2, 15, 0, 'h27); tbl[11] = rtype(1, 2, 16, 0, 'h2A);
    tbl[12] = rtype(1, 2, 17, 0, 'h2B); tbl[13] = rtype(1, 2, 18, 0, 'h01);
    tbl[14] = itype('h08, 3, 19, 'h8000); tbl[15] = itype('h0A, 3, 20, 'hFFFE);
    tbl[16] = itype('h0B, 3, 21, 'h9000); tbl[17] = itype('h0C, 3, 22, 'h8001);
    tbl[18] = itype('h0E, 3, 23, 'hF0F0); tbl[19] = itype('h01, 3, 24, 'h0001);
    tbl[20] = rtype(1, 2, 25, 0, 'h20);  tbl[21] = rtype(1, 2, 26, 0, 'h22);
    tbl[22] = itype('h23, 3, 27, 'h0004); tbl[23] = rtype(1, 2, 28, 0, 'h08);
    for (int i = 0; i < 60; i++) begin
      in_inst     = tbl[i % 24];
      rs_value    = $urandom;
      rt_value    = $urandom;
      in_pc       = $urandom;
      in_valid    = ($urandom_range(3) != 0);
      out_allowin = ($urandom_range(2) != 0);
      flush       = ($urandom_range(15) == 0);
      step();
    end
    in_valid = 1'b0; flush = 1'b0; out_allowin = 1'b1;
    step(); step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_decode_stage.md
ALU_DECODE_STAGE -- requirements
Module: alu_decode_stage

Interface
REQ-001 clk  in  1  single clock; all state updates on its rising edge.
REQ-002 reset  in  1  synchronous, active-high reset.
REQ-003 in_valid  in  1  upstream holds a valid instruction.
REQ-004 in_allowin  out  1  stage can accept a new instruction this cycle.
REQ-005 in_inst  in  32  MIPS instruction word.
REQ-006 in_pc  in  32  instruction PC.
REQ-007 rs_value / rt_value  in  32 each  register-file read data for inst[25:21] / inst[20:16].
REQ-008 flush  in  1  discard held and incoming instruction.
REQ-009 out_valid  out  1  registered instruction presented to execute stage.
REQ-010 out_allowin  in  1  execute stage accepts this cycle.
REQ-011 out_alu_op  out  15  one-hot ALU op: bit0 and, 1 or, 2 xor, 3 nor, 4 add, 5 sub, 6 slt, 7 sll, 8 srl, 9 sllv, 10 srlv, 11 sltu, 12 lui, 13 sra, 14 srav.
REQ-012 out_alu_a / out_alu_b  out  32 each  ALU operands A / B.
REQ-013 out_shamt  out  5  inst[10:6].
REQ-014 out_dest  out  5  destination register number.
REQ-015 out_pc  out  32  registered in_pc.
REQ-016 out_ovf_trap  out  1  ALU overflow must raise exception (ADD, ADDI, SUB).
REQ-017 out_illegal  out  1  opcode/funct not supported.

Function
REQ-018 Handshake: in_allowin = !out_valid | out_allowin; transfer when in_valid & in_allowin.
REQ-019 On transfer, all out_* payload registers load decoded in_inst fields on the next edge; latency exactly 1 cycle.
REQ-020 out_valid next = flush ? 0 : (in_allowin ? in_valid : out_valid).
REQ-021 When out_valid=1 and out_allowin=0, all outputs shall hold unchanged.
REQ-022 Payload registers shall load only on transfer; they may hold stale data while out_valid=0.
REQ-023 R-type (opcode 0): funct 00/02/03 -> sll/srl/sra; 04/06/07 -> sllv/srlv/srav; 20,21 -> add; 22,23 -> sub; 24 and; 25 or; 26 xor; 27 nor; 2A slt; 2B sltu; A=rs_value, B=rt_value, dest=inst[15:11].
REQ-024 I-type: opcode 08,09 add; 0A slt; 0B sltu (B sign-extended); 0C and; 0D or; 0E xor (B zero-extended); 0F lui (B = zero-extended imm); A=rs_value, dest=inst[20:16].
REQ-025 Sign extension for 08-0B; zero extension for 0C-0F.
REQ-026 out_ovf_trap=1 only for funct 20, 22 and opcode 08.
REQ-027 Any other encoding: out_alu_op=0, out_dest=0, out_illegal=1, out_ovf_trap=0.
REQ-028 Exactly one out_alu_op bit set for every legal instruction.
REQ-029 flush takes priority over transfer; a transfer in the flush cycle is dropped.

Reset
REQ-030 On reset, out_valid=0; all payload outputs=0; in_allowin=1 in the following cycle.
REQ-031 Reset mid-stall discards the held instruction with no output transfer.

Structure
REQ-032 Shared package holds ALU op bit-index constants, opcode/funct constants and the 15-bit op width.
REQ-033 One combinational sub-module, alu_op_decoder (inst -> alu_op, imm select, dest select, trap, illegal), plus this module's pipeline register.

Verification
REQ-034 in_inst=0x2422FFFF, rs_value=5 -> next cycle out_valid=1, out_alu_op=0x0010, out_alu_b=0xFFFFFFFF, out_dest=2, out_ovf_trap=0.
REQ-035 in_inst=0x3422FFFF then 0x3C031234 back-to-back, out_allowin=1 -> out_alu_op 0x0002/B=0x0000FFFF, then 0x1000/B=0x00001234, dest 3.
REQ-036 in_inst=0x000520C3, rt_value=0x80000000 -> out_alu_op=0x2000, out_shamt=3, out_dest=4, out_alu_b=0x80000000.
REQ-037 out_valid=1, out_allowin=0 for 3 cycles with new in_inst presented -> in_allowin=0, outputs unchanged; release -> next instruction appears 1 cycle later.
REQ-038 in_inst=0xFC000000 -> out_illegal=1, out_alu_op=0; flush with in_valid=1 -> out_valid=0 next cycle.
REQ-039 reset asserted during stall -> out_valid=0, all outputs 0, in_allowin=1 next cycle.
